// File: rtl/mult_job_sequencer.sv
// mult_job_sequencer
//   Queues operand pairs from an upstream valid/ready producer in a small FIFO and
//   runs them through a start/done sequential multiplier one job at a time. Each
//   product is held until the downstream consumer accepts it; only then is the
//   next job issued, so products leave in strict acceptance order.
//
// Ports
//   clk, rst          clock, asynchronous active-low reset
//   in_valid/ready    operand handshake; in_ready depends on fifo_count only
//   in_multiplier     operand A
//   in_multiplicand   operand B
//   mul_start         one-cycle start pulse to the multiplier
//   mul_multiplier    registered operand A, held for the whole job
//   mul_multiplicand  registered operand B, held for the whole job
//   mul_product       multiplier result (2*WIDTH)
//   mul_done          multiplier productDone
//   out_valid/ready   result handshake
//   out_product       registered product
//   busy              high whenever the FSM is not idle
//   fifo_count        FIFO occupancy

module mult_job_sequencer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_multiplier,
    input  logic [WIDTH-1:0]         in_multiplicand,
    output logic                     mul_start,
    output logic [WIDTH-1:0]         mul_multiplier,
    output logic [WIDTH-1:0]         mul_multiplicand,
    input  logic [2*WIDTH-1:0]       mul_product,
    input  logic                     mul_done,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2*WIDTH-1:0]       out_product,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {st_idle, st_issue, st_wait, st_hold} state_t;

    state_t           state_q;
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    // Set on entry to WAIT: the first WAIT cycle may still see the previous
    // job's done, so done is only honoured from the second cycle on.
    logic             wait_first_q;

    logic [WIDTH-1:0] mem_a [DEPTH];
    logic [WIDTH-1:0] mem_b [DEPTH];

    logic push;
    logic pop;

    assign in_ready = (fifo_count != FULL);
    assign push     = in_valid && in_ready;
    assign pop      = (state_q == st_idle) && (fifo_count != '0);
    assign busy     = (state_q != st_idle);

    // Storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr_q] <= in_multiplier;
            mem_b[wr_ptr_q] <= in_multiplicand;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= st_idle;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            fifo_count       <= '0;
            wait_first_q     <= 1'b0;
            mul_start        <= 1'b0;
            mul_multiplier   <= '0;
            mul_multiplicand <= '0;
            out_valid        <= 1'b0;
            out_product      <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end

            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase

            case (state_q)
                st_idle: begin
                    if (pop) begin
                        mul_multiplier   <= mem_a[rd_ptr_q];
                        mul_multiplicand <= mem_b[rd_ptr_q];
                        mul_start        <= 1'b1;
                        state_q          <= st_issue;
                    end
                end
                st_issue: begin
                    mul_start    <= 1'b0;
                    wait_first_q <= 1'b1;
                    state_q      <= st_wait;
                end
                st_wait: begin
                    if (wait_first_q) begin
                        wait_first_q <= 1'b0;
                    end else if (mul_done) begin
                        out_product <= mul_product;
                        out_valid   <= 1'b1;
                        state_q     <= st_hold;
                    end
                end
                st_hold: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state_q   <= st_idle;
                    end
                end
                default: state_q <= st_idle;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_job_sequencer.sv
module tb_mult_job_sequencer;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 4;
    localparam int          LAT   = 3;

    logic                   clk;
    logic                   rst;
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       in_multiplier;
    logic [WIDTH-1:0]       in_multiplicand;
    logic                   mul_start;
    logic [WIDTH-1:0]       mul_multiplier;
    logic [WIDTH-1:0]       mul_multiplicand;
    logic [2*WIDTH-1:0]     mul_product;
    logic                   mul_done;
    logic                   out_valid;
    logic                   out_ready;
    logic [2*WIDTH-1:0]     out_product;
    logic                   busy;
    logic [$clog2(DEPTH):0] fifo_count;

    int errors = 0;
    int checks = 0;
    int start_cnt = 0;

    // Behavioural multiplier: done pulses LAT cycles after start.
    int                 m_cnt;
    logic               done_r;
    logic               spur_done;
    logic [2*WIDTH-1:0] prod_r;

    assign mul_done    = done_r | spur_done;
    assign mul_product = prod_r;

    mult_job_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_multiplier    (in_multiplier),
        .in_multiplicand  (in_multiplicand),
        .mul_start        (mul_start),
        .mul_multiplier   (mul_multiplier),
        .mul_multiplicand (mul_multiplicand),
        .mul_product      (mul_product),
        .mul_done         (mul_done),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_product      (out_product),
        .busy             (busy),
        .fifo_count       (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_cnt  <= 0;
            done_r <= 1'b0;
            prod_r <= '0;
        end else begin
            done_r <= 1'b0;
            if (mul_start) begin
                m_cnt  <= LAT;
                prod_r <= {32'b0, mul_multiplier} * {32'b0, mul_multiplicand};
            end else if (m_cnt != 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) done_r <= 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        if (mul_start) start_cnt <= start_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!out_valid && n < 60) begin
            step();
            n++;
        end
        chk(tag, 64'(out_valid), 64'd1);
    endtask

    int  s0;
    int  n;
    bit  bad;
    bit  was_ready;

    initial begin
        rst = 1'b0;
        in_valid = 1'b0;
        in_multiplier = '0;
        in_multiplicand = '0;
        out_ready = 1'b0;
        spur_done = 1'b0;
        #2;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_mul_start", 64'(mul_start), 64'd0);
        chk("rst_fifo_count", 64'(fifo_count), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_product", out_product, 64'd0);
        chk("rst_mul_multiplier", 64'(mul_multiplier), 64'd0);
        step();
        step();
        rst = 1'b1;
        step();

        // Single job 7*6
        out_ready = 1'b1;
        s0 = start_cnt;
        in_valid = 1'b1; in_multiplier = 7; in_multiplicand = 6;
        step();
        in_valid = 1'b0;
        chk("t1_count_after_push", 64'(fifo_count), 64'd1);
        chk("t1_no_start_yet", 64'(mul_start), 64'd0);
        step();
        chk("t1_start", 64'(mul_start), 64'd1);
        chk("t1_opa", 64'(mul_multiplier), 64'd7);
        chk("t1_opb", 64'(mul_multiplicand), 64'd6);
        chk("t1_busy", 64'(busy), 64'd1);
        chk("t1_count_after_pop", 64'(fifo_count), 64'd0);
        step();
        chk("t1_start_one_cycle", 64'(mul_start), 64'd0);
        n = 0;
        while (!mul_done && n < 20) begin
            step();
            n++;
        end
        chk("t1_done_seen", 64'(mul_done), 64'd1);
        chk("t1_valid_not_before_done", 64'(out_valid), 64'd0);
        step();
        chk("t1_valid_after_done", 64'(out_valid), 64'd1);
        chk("t1_product", out_product, 64'd42);
        step();
        chk("t1_valid_cleared", 64'(out_valid), 64'd0);
        chk("t1_idle", 64'(busy), 64'd0);
        chk("t1_one_start", 64'(start_cnt - s0), 64'd1);

        // Back-pressure on max operands
        out_ready = 1'b0;
        in_valid = 1'b1; in_multiplier = 32'hFFFF_FFFF; in_multiplicand = 32'hFFFF_FFFF;
        step();
        in_valid = 1'b0;
        wait_valid("t2_valid");
        chk("t2_product", out_product, 64'hFFFF_FFFE_0000_0001);
        in_valid = 1'b1; in_multiplier = 2; in_multiplicand = 3;
        step();
        in_valid = 1'b0;
        s0 = start_cnt;
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!out_valid || out_product !== 64'hFFFF_FFFE_0000_0001) bad = 1'b1;
            step();
        end
        chk("t2_held_stable", 64'(bad), 64'd0);
        chk("t2_no_second_start", 64'(start_cnt - s0), 64'd0);
        chk("t2_queued", 64'(fifo_count), 64'd1);
        out_ready = 1'b1;
        step();
        chk("t2_released", 64'(out_valid), 64'd0);
        wait_valid("t2_next_valid");
        chk("t2_next_product", out_product, 64'd6);
        step();

        // FIFO full: job 9*9 in flight, then pairs 1..5
        out_ready = 1'b0;
        in_valid = 1'b1; in_multiplier = 9; in_multiplicand = 9;
        step();
        in_valid = 1'b0;
        step();
        chk("t3_busy", 64'(busy), 64'd1);
        for (int k = 1; k <= 4; k++) begin
            in_valid = 1'b1; in_multiplier = k; in_multiplicand = k;
            step();
        end
        in_multiplier = 5; in_multiplicand = 5;
        chk("t3_full_count", 64'(fifo_count), 64'd4);
        chk("t3_full_not_ready", 64'(in_ready), 64'd0);
        step();
        step();
        chk("t3_blocked", 64'(fifo_count), 64'd4);
        wait_valid("t3_first_valid");
        chk("t3_first_product", out_product, 64'd81);
        chk("t3_still_full", 64'(fifo_count), 64'd4);
        out_ready = 1'b1;
        n = 0;
        was_ready = 1'b0;
        while (!was_ready && n < 30) begin
            was_ready = in_ready;
            step();
            n++;
        end
        in_valid = 1'b0;
        chk("t3_fifth_accepted", 64'(was_ready), 64'd1);
        chk("t3_count_after_fifth", 64'(fifo_count), 64'd4);
        for (int k = 1; k <= 5; k++) begin
            wait_valid($sformatf("t3_valid_%0d", k));
            chk($sformatf("t3_product_%0d", k), out_product, 64'(k * k));
            step();
        end

        // Push on the same edge as the pop
        in_valid = 1'b1; in_multiplier = 2; in_multiplicand = 5;
        step();
        in_multiplier = 3; in_multiplicand = 7;
        step();
        in_valid = 1'b0;
        chk("t4_count_unchanged", 64'(fifo_count), 64'd1);
        chk("t4_start", 64'(mul_start), 64'd1);
        chk("t4_first_opa", 64'(mul_multiplier), 64'd2);
        wait_valid("t4_valid_a");
        chk("t4_product_a", out_product, 64'd10);
        step();
        wait_valid("t4_valid_b");
        chk("t4_product_b", out_product, 64'd21);
        chk("t4_second_opa", 64'(mul_multiplier), 64'd3);
        step();

        // Reset while in WAIT with two queued
        out_ready = 1'b0;
        in_valid = 1'b1; in_multiplier = 4; in_multiplicand = 4;
        step();
        in_multiplier = 5; in_multiplicand = 5;
        step();
        in_multiplier = 6; in_multiplicand = 6;
        step();
        in_valid = 1'b0;
        chk("t5_pre_busy", 64'(busy), 64'd1);
        chk("t5_pre_count", 64'(fifo_count), 64'd2);
        #1;
        rst = 1'b0;
        #1;
        chk("t5_out_valid", 64'(out_valid), 64'd0);
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_count", 64'(fifo_count), 64'd0);
        chk("t5_start", 64'(mul_start), 64'd0);
        rst = 1'b1;
        s0 = start_cnt;
        bad = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (out_valid || mul_start || busy) bad = 1'b1;
        end
        chk("t5_quiet_after_reset", 64'(bad), 64'd0);
        chk("t5_no_start_after_reset", 64'(start_cnt - s0), 64'd0);

        // Spurious done in IDLE and HOLD
        spur_done = 1'b1;
        step();
        step();
        spur_done = 1'b0;
        chk("t6_idle_product", out_product, 64'd0);
        chk("t6_idle_valid", 64'(out_valid), 64'd0);
        chk("t6_idle_busy", 64'(busy), 64'd0);
        in_valid = 1'b1; in_multiplier = 3; in_multiplicand = 3;
        step();
        in_valid = 1'b0;
        wait_valid("t6_valid");
        chk("t6_product", out_product, 64'd9);
        spur_done = 1'b1;
        step();
        step();
        spur_done = 1'b0;
        chk("t6_hold_valid", 64'(out_valid), 64'd1);
        chk("t6_hold_product", out_product, 64'd9);
        chk("t6_hold_busy", 64'(busy), 64'd1);
        out_ready = 1'b1;
        step();
        chk("t6_consumed", 64'(out_valid), 64'd0);
        chk("t6_idle_again", 64'(busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mult_job_sequencer.md
Name: mult_job_sequencer

Overview:
- Front-end/back-end wrapper around the sequential multiplier (start / productDone interface).
- Buffers operand pairs from an upstream valid/ready producer in a small FIFO and issues them to the multiplier one job at a time.
- Holds each product until a downstream valid/ready consumer accepts it, then issues the next job.
- Sits directly between the operand source and the multiplier's start, multiplier and multiplicand inputs, and between the multiplier's product/productDone outputs and the result sink.

Parameters:
- WIDTH, 32: operand width; product is 2*WIDTH.
- DEPTH, 4: operand FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- in_valid  in  1  operand pair offered.
- in_ready  out  1  FIFO can accept; equals (fifo_count != DEPTH).
- in_multiplier  in  WIDTH  operand A.
- in_multiplicand  in  WIDTH  operand B.
- mul_start  out  1  one-cycle start pulse to the multiplier.
- mul_multiplier  out  WIDTH  registered operand A, stable for the whole job.
- mul_multiplicand  out  WIDTH  registered operand B, stable for the whole job.
- mul_product  in  2*WIDTH  multiplier result.
- mul_done  in  1  multiplier productDone.
- out_valid  out  1  product available.
- out_ready  in  1  consumer accepts.
- out_product  out  2*WIDTH  registered product.
- busy  out  1  high whenever state != IDLE.
- fifo_count  out  $clog2(DEPTH)+1  occupancy.

Behaviour:
- Reset (rst=0, asynchronous):
  - State = IDLE; FIFO pointers and count = 0.
  - mul_start = 0, out_valid = 0, busy = 0.
  - mul_multiplier, mul_multiplicand and out_product = 0.
- Reset mid-job: everything above is cleared, including the in-flight job. The multiplier is reset by the same rst.
- Push: occurs on a clk edge when in_valid && in_ready.
- Pop: occurs only on the IDLE->ISSUE transition.
- Push and pop in the same cycle: count is unchanged. When full, in_ready=0, so no push can occur that cycle.
- Pointers wrap modulo DEPTH.
- FSM:
  - IDLE: if count != 0, pop the head into mul_multiplier/mul_multiplicand and go to ISSUE.
  - ISSUE: mul_start=1 for exactly this one cycle; next state WAIT.
  - WAIT: when mul_done=1, capture mul_product into out_product, set out_valid=1, go to HOLD. mul_done is ignored in every other state. The first cycle of WAIT may see a stale mul_done: it is qualified only from the second WAIT cycle onward.
  - HOLD: out_valid=1 and out_product stable until out_ready=1. On the handshake edge, out_valid goes to 0 and the state returns to IDLE.
- Latency:
  - Operand accepted into an empty FIFO while IDLE -> mul_start asserted 2 cycles later.
  - mul_done -> out_valid high on the next cycle.
  - Minimum gap between consecutive mul_start pulses = multiplier latency + 4 cycles.
- mul_multiplier and mul_multiplicand change only on pops and are held through ISSUE, WAIT and HOLD.
- Product width: out_product is exactly mul_product (2*WIDTH); no truncation or sign handling (unsigned).
- in_ready is combinational from count only. It does not depend on in_valid or on the FSM state.
- Ordering: products are delivered in strict FIFO order of operand acceptance; exactly one job is in flight at a time.

Test Plan:
- Single job, WIDTH=32: push A=7, B=6 with out_ready=1.
  -> Exactly one mul_start pulse 2 cycles after the push.
  -> out_valid with out_product=42 the cycle after mul_done; busy returns to 0.
- Back-pressure: push A=0xFFFFFFFF, B=0xFFFFFFFF with out_ready=0 for 20 cycles.
  -> out_product=0xFFFFFFFE00000001 held stable with out_valid=1.
  -> No second mul_start until out_ready is raised.
- FIFO full: push 5 pairs back-to-back while the first job runs.
  -> fifo_count reaches 4 and in_ready=0.
  -> The blocked 5th pair is accepted once the pop occurs.
  -> All 5 products (1*1, 2*2, 3*3, 4*4, 5*5) are delivered in order.
- Simultaneous push/pop: push a pair on the same edge as the IDLE->ISSUE pop with count=1.
  -> count stays 1; the next job uses the newly pushed pair.
- Reset mid-operation: drive rst=0 while in WAIT with 2 entries queued.
  -> Immediately: out_valid=0, busy=0, fifo_count=0, mul_start=0.
  -> After reset release: no product is emitted without a new push.
- Spurious done: pulse mul_done while in IDLE and while in HOLD.
  -> No change to out_product or the state.
